// File: rtl/sram_byte_write_controller_if.sv
// Client request/response and SRAM macro signals for the byte-write controller.
// The controller takes the slave view; the environment takes the master view.
interface sram_byte_write_controller_if;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_address;
  logic [BE_W-1:0]   req_byte_enables;
  logic [DATA_W-1:0] req_write_data;
  logic              req_ack;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              busy;
  logic              sram_read;
  logic              sram_write;
  logic [ADDR_W-1:0] sram_address;
  logic [DATA_W-1:0] sram_write_data;
  logic [DATA_W-1:0] sram_read_data;

  modport slave (
    input  req_valid, req_write, req_address, req_byte_enables, req_write_data,
    input  sram_read_data,
    output req_ack, resp_valid, resp_data, busy,
    output sram_read, sram_write, sram_address, sram_write_data
  );

  modport master (
    output req_valid, req_write, req_address, req_byte_enables, req_write_data,
    output sram_read_data,
    input  req_ack, resp_valid, resp_data, busy,
    input  sram_read, sram_write, sram_address, sram_write_data
  );
endinterface

// File: rtl/sram_byte_write_controller.sv
// Single-outstanding read/byte-write controller for a 2048x32 SRAM without byte lanes.
// Partial-word writes become read-modify-write; an all-zero byte mask is acked and dropped.
module sram_byte_write_controller (
  input  logic                          sram_clock,
  input  logic                          sram_reset,
  sram_byte_write_controller_if.slave   bus
);
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    READ_DATA,
    RMW_READ,
    RMW_MERGE,
    WRITE
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [BE_W-1:0]   be_q;
  logic              rd_q;
  logic              wr_q;
  logic              resp_q;
  logic              busy_q;

  // Strobes, response flag and busy are registered alongside the state transition.
  always_ff @(posedge sram_clock) begin
    if (sram_reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      resp_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q <= bus.req_address;
            data_q <= bus.req_write_data;
            be_q   <= bus.req_byte_enables;
            if (!bus.req_write) begin
              state_q <= READ;
              rd_q    <= 1'b1;
              busy_q  <= 1'b1;
            end else if (bus.req_byte_enables == 4'hF) begin
              state_q <= WRITE;
              wr_q    <= 1'b1;
              busy_q  <= 1'b1;
            end else if (bus.req_byte_enables != 4'h0) begin
              state_q <= RMW_READ;
              rd_q    <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        READ: begin
          state_q <= READ_DATA;
          resp_q  <= 1'b1;
        end
        READ_DATA: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        RMW_READ: begin
          state_q <= RMW_MERGE;
        end
        RMW_MERGE: begin
          // Keep enabled client bytes, fill the rest from the old SRAM word.
          for (int n = 0; n < 4; n++) begin
            if (!be_q[n]) data_q[8*n +: 8] <= bus.sram_read_data[8*n +: 8];
          end
          state_q <= WRITE;
          wr_q    <= 1'b1;
        end
        WRITE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ack         = bus.req_valid & (state_q == IDLE);
  assign bus.resp_valid      = resp_q;
  assign bus.resp_data       = resp_q ? bus.sram_read_data : 32'h0;
  assign bus.busy            = busy_q;
  assign bus.sram_read       = rd_q;
  assign bus.sram_write      = wr_q;
  assign bus.sram_address    = addr_q;
  assign bus.sram_write_data = data_q;
endmodule

// File: tb/tb_sram_byte_write_controller.sv
// Directed bench for sram_byte_write_controller with a behavioural 2048x32 SRAM macro.
module tb_sram_byte_write_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;

  sram_byte_write_controller_if bus_if ();

  sram_byte_write_controller dut (
    .sram_clock (clk),
    .sram_reset (rst),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  // SRAM macro: registered read, whole-word write.
  logic [31:0] mem [0:2047];
  logic [31:0] rdata;
  always @(posedge clk) begin
    if (bus_if.sram_write) mem[bus_if.sram_address] <= bus_if.sram_write_data;
    if (bus_if.sram_read)  rdata <= mem[bus_if.sram_address];
  end
  assign bus_if.sram_read_data = rdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request in IDLE, confirm the ack, and retire it after the edge.
  task automatic issue(input string tag, input logic wr, input logic [10:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    bus_if.req_valid        = 1'b1;
    bus_if.req_write        = wr;
    bus_if.req_address      = a;
    bus_if.req_byte_enables = be;
    bus_if.req_write_data   = d;
    #1;
    chk({tag, "_ack"}, 32'(bus_if.req_ack), 32'd1);
    tick();
    bus_if.req_valid = 1'b0;
  endtask

  task automatic full_write(input logic [10:0] a, input logic [31:0] d);
    issue("pre_wr", 1'b1, a, 4'hF, d);
    tick();
  endtask

  task automatic do_read(input string tag, input logic [10:0] a, input logic [31:0] exp);
    issue(tag, 1'b0, a, 4'h0, 32'h0);
    chk({tag, "_rd_strobe"}, 32'(bus_if.sram_read), 32'd1);
    chk({tag, "_rd_addr"}, 32'(bus_if.sram_address), 32'(a));
    tick();
    chk({tag, "_resp_valid"}, 32'(bus_if.resp_valid), 32'd1);
    chk({tag, "_resp_data"}, bus_if.resp_data, exp);
    tick();
    chk({tag, "_resp_done"}, {30'h0, bus_if.resp_valid, bus_if.busy}, 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [10:0] a;
    logic [3:0]  be;
    logic [31:0] d;
    logic [31:0] exp;
  } op_t;

  initial begin
    op_t ops [7];
    bit  pend;
    logic [31:0] pend_exp;
    bit  acked;
    int  acks;

    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    rdata = 32'h0;
    bus_if.req_valid = 1'b0;
    bus_if.req_write = 1'b0;
    bus_if.req_address = '0;
    bus_if.req_byte_enables = '0;
    bus_if.req_write_data = '0;

    // Reset values
    rst = 1'b1;
    tick();
    chk("rst_outputs", {26'h0, bus_if.req_ack, bus_if.resp_valid, bus_if.busy,
                        bus_if.sram_read, bus_if.sram_write, 1'b0}, 32'd0);
    chk("rst_resp_data", bus_if.resp_data, 32'h0);
    chk("rst_addr", 32'(bus_if.sram_address), 32'd0);
    chk("rst_wdata", bus_if.sram_write_data, 32'h0);
    rst = 1'b0;
    tick();

    // Full write then read
    issue("fw", 1'b1, 11'h005, 4'hF, 32'hDEADBEEF);
    chk("fw_wr_strobe", 32'(bus_if.sram_write), 32'd1);
    chk("fw_no_rd", 32'(bus_if.sram_read), 32'd0);
    chk("fw_addr", 32'(bus_if.sram_address), 32'h005);
    chk("fw_wdata", bus_if.sram_write_data, 32'hDEADBEEF);
    chk("fw_busy", 32'(bus_if.busy), 32'd1);
    tick();
    chk("fw_idle", {30'h0, bus_if.busy, bus_if.sram_write}, 32'd0);
    do_read("rd5", 11'h005, 32'hDEADBEEF);

    // Partial read-modify-write
    full_write(11'h7FF, 32'h11223344);
    issue("rmw", 1'b1, 11'h7FF, 4'b0101, 32'hAABBCCDD);
    chk("rmw_rd", {30'h0, bus_if.sram_read, bus_if.sram_write}, 32'd2);
    tick();
    chk("rmw_merge", {29'h0, bus_if.busy, bus_if.sram_read, bus_if.sram_write}, 32'd4);
    tick();
    chk("rmw_wr", {30'h0, bus_if.sram_read, bus_if.sram_write}, 32'd1);
    chk("rmw_wdata", bus_if.sram_write_data, 32'h11BB33DD);
    tick();
    chk("rmw_done", 32'(bus_if.busy), 32'd0);
    do_read("rd7ff", 11'h7FF, 32'h11BB33DD);

    // Null write is acked and dropped
    full_write(11'h010, 32'h55667788);
    issue("null", 1'b1, 11'h010, 4'h0, 32'hFFFFFFFF);
    chk("null_quiet", {29'h0, bus_if.busy, bus_if.sram_read, bus_if.sram_write}, 32'd0);
    do_read("rd10", 11'h010, 32'h55667788);

    // Back-to-back traffic with req_valid held
    ops[0] = '{1'b0, 11'h005, 4'h0,    32'h0,        32'hDEADBEEF};
    ops[1] = '{1'b1, 11'h7FF, 4'b1010, 32'h99AA00EE, 32'h0};
    ops[2] = '{1'b0, 11'h7FF, 4'h0,    32'h0,        32'h99BB00DD};
    ops[3] = '{1'b1, 11'h005, 4'b0011, 32'h0000CAFE, 32'h0};
    ops[4] = '{1'b0, 11'h005, 4'h0,    32'h0,        32'hDEADCAFE};
    ops[5] = '{1'b1, 11'h010, 4'b1000, 32'hAB000000, 32'h0};
    ops[6] = '{1'b0, 11'h010, 4'h0,    32'h0,        32'hAB667788};
    pend = 1'b0;
    pend_exp = 32'h0;
    acks = 0;
    for (int i = 0; i < 7; i++) begin
      bus_if.req_valid        = 1'b1;
      bus_if.req_write        = ops[i].wr;
      bus_if.req_address      = ops[i].a;
      bus_if.req_byte_enables = ops[i].be;
      bus_if.req_write_data   = ops[i].d;
      #1;
      acked = 1'b0;
      for (int c = 0; c < 12 && !acked; c++) begin
        chk("b2b_overlap", 32'(bus_if.sram_read & bus_if.sram_write), 32'd0);
        if (bus_if.resp_valid) begin
          chk("b2b_resp", bus_if.resp_data, pend_exp);
          pend = 1'b0;
        end
        if (bus_if.req_ack) begin
          chk("b2b_ack_idle", 32'(bus_if.busy), 32'd0);
          acked = 1'b1;
          acks++;
        end
        tick();
      end
      chk("b2b_ack_timeout", 32'(acked), 32'd1);
      if (!ops[i].wr) begin
        pend = 1'b1;
        pend_exp = ops[i].exp;
      end
    end
    bus_if.req_valid = 1'b0;
    for (int c = 0; c < 6 && pend; c++) begin
      if (bus_if.resp_valid) begin
        chk("b2b_resp_last", bus_if.resp_data, pend_exp);
        pend = 1'b0;
      end
      tick();
    end
    chk("b2b_resp_timeout", 32'(pend), 32'd0);
    chk("b2b_ack_count", 32'(acks), 32'd7);

    // Reset in the merge cycle aborts the RMW
    tick();
    full_write(11'h020, 32'h0BADF00D);
    issue("abort", 1'b1, 11'h020, 4'b0001, 32'h000000FF);
    chk("abort_rd", 32'(bus_if.sram_read), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    chk("abort_quiet", {29'h0, bus_if.busy, bus_if.sram_read, bus_if.sram_write}, 32'd0);
    rst = 1'b0;
    tick();
    chk("abort_still_quiet", 32'(bus_if.sram_write), 32'd0);
    do_read("rd20", 11'h020, 32'h0BADF00D);

    // Reset clears registered address/data left by prior traffic
    rst = 1'b1;
    tick();
    chk("rst2_addr", 32'(bus_if.sram_address), 32'd0);
    chk("rst2_wdata", bus_if.sram_write_data, 32'h0);
    chk("rst2_flags", {27'h0, bus_if.req_ack, bus_if.resp_valid, bus_if.busy,
                       bus_if.sram_read, bus_if.sram_write}, 32'd0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
